// File: rtl/uart_pkg.sv
// Shared UART definitions: receive FSM encoding, default frame width and baud timing.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_e;

  localparam int UART_DATA_BITS_DEF = 8;
  localparam int BPS_PERIOD         = 1736;
  localparam int BPS_HALF           = 868;

endpackage

// File: rtl/rx_detect_module.sv
// Serial line conditioner: 2-FF synchronizer, history register and registered
// high-to-low edge strobe.
module rx_detect_module (
  input  logic CLK,
  input  logic RSTn,
  input  logic RX_Pin_In,
  output logic RX_Sync,
  output logic H2L_Sig
);

  logic sync1_q;
  logic sync2_q;
  logic hist_q;
  logic h2l_q;

  // Synchronize the asynchronous line and flag a 1->0 step of the synced value.
  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      hist_q  <= 1'b1;
      h2l_q   <= 1'b0;
    end else begin
      sync1_q <= RX_Pin_In;
      sync2_q <= sync1_q;
      hist_q  <= sync2_q;
      h2l_q   <= hist_q & ~sync2_q;
    end
  end

  assign RX_Sync = sync2_q;
  assign H2L_Sig = h2l_q;

endmodule

// File: rtl/uart_rx_ctrl_module.sv
// UART receive controller: gates the external baud counter, samples start,
// data (LSB first) and stop bits on BPS_CLK, and strobes done or framing error.
module uart_rx_ctrl_module
  import uart_pkg::*;
#(
  parameter int DATA_BITS = UART_DATA_BITS_DEF
) (
  input  logic                 CLK,
  input  logic                 RSTn,
  input  logic                 RX_Pin_In,
  input  logic                 RX_En_Sig,
  input  logic                 BPS_CLK,
  output logic                 Count_Sig,
  output logic [DATA_BITS-1:0] RX_Data,
  output logic                 RX_Done_Sig,
  output logic                 RX_Err_Sig
);

  localparam int IDX_W = $clog2(DATA_BITS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

  logic rx_sync;
  logic h2l;

  rx_state_e            state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [IDX_W-1:0]     idx_q,   idx_d;
  logic [DATA_BITS-1:0] data_q,  data_d;
  logic                 done_q,  done_d;
  logic                 err_q,   err_d;
  logic                 count_q, count_d;

  rx_detect_module u_detect (
    .CLK       (CLK),
    .RSTn      (RSTn),
    .RX_Pin_In (RX_Pin_In),
    .RX_Sync   (rx_sync),
    .H2L_Sig   (h2l)
  );

  // Frame sequencing, bit capture and strobe generation.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    idx_d   = idx_q;
    data_d  = data_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (h2l && RX_En_Sig) state_d = START;
      end
      START: begin
        if (BPS_CLK) begin
          if (!rx_sync) begin
            state_d = DATA;
            idx_d   = '0;
          end else begin
            state_d = IDLE;  // start bit not confirmed at mid-bit: glitch
          end
        end
      end
      DATA: begin
        if (BPS_CLK) begin
          shift_d[idx_q] = rx_sync;
          if (idx_q == LAST_IDX) state_d = STOP;
          else                   idx_d   = idx_q + IDX_W'(1);
        end
      end
      STOP: begin
        if (BPS_CLK) begin
          if (rx_sync) begin
            data_d = shift_q;
            done_d = 1'b1;
          end else begin
            err_d  = 1'b1;
          end
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // Disabling the receiver abandons any frame silently.
    if (state_q != IDLE && !RX_En_Sig) begin
      state_d = IDLE;
      shift_d = shift_q;
      idx_d   = idx_q;
      data_d  = data_q;
      done_d  = 1'b0;
      err_d   = 1'b0;
    end
    // Counter runs one cycle after entering START and drops with the return to IDLE,
    // so it always sees at least one low cycle between frames.
    count_d = (state_q != IDLE) && (state_d != IDLE);
  end

  // State and output registers.
  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      state_q <= IDLE;
      shift_q <= '0;
      idx_q   <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      count_q <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      done_q  <= done_d;
      err_q   <= err_d;
      count_q <= count_d;
    end
  end

  assign Count_Sig   = count_q;
  assign RX_Data     = data_q;
  assign RX_Done_Sig = done_q;
  assign RX_Err_Sig  = err_q;

endmodule

// File: tb/tb_uart_rx_ctrl_module.sv
// Directed bench for uart_rx_ctrl_module with a behavioural baud counter.
module tb_uart_rx_ctrl_module;
  import uart_pkg::*;

  logic       CLK = 1'b0;
  logic       RSTn;
  logic       rx_line;
  logic       rx_en;
  logic       bps_force;
  logic       bps_clk;
  logic       Count_Sig;
  logic [7:0] RX_Data;
  logic       RX_Done_Sig;
  logic       RX_Err_Sig;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;
  int done_cnt = 0;
  int err_cnt  = 0;
  int done_cyc = 0;
  int start_cyc = 0;
  int bit_len  = BPS_PERIOD;
  int half_len = BPS_HALF;
  int bps_cnt  = 0;
  logic [7:0] data_log[$];

  uart_rx_ctrl_module #(.DATA_BITS(8)) dut (
    .CLK         (CLK),
    .RSTn        (RSTn),
    .RX_Pin_In   (rx_line),
    .RX_En_Sig   (rx_en),
    .BPS_CLK     (bps_clk),
    .Count_Sig   (Count_Sig),
    .RX_Data     (RX_Data),
    .RX_Done_Sig (RX_Done_Sig),
    .RX_Err_Sig  (RX_Err_Sig)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  // Baud counter model; period selectable at runtime.
  always @(posedge CLK) begin
    if (!Count_Sig)                 bps_cnt <= 0;
    else if (bps_cnt == bit_len-1)  bps_cnt <= 0;
    else                            bps_cnt <= bps_cnt + 1;
  end
  assign bps_clk = (Count_Sig && bps_cnt == half_len) || bps_force;

  // Strobe monitor.
  always @(negedge CLK) begin
    if (RX_Done_Sig) begin
      done_cnt = done_cnt + 1;
      done_cyc = cyc;
      data_log.push_back(RX_Data);
    end
    if (RX_Err_Sig) err_cnt = err_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  task automatic drive_bit(input logic v);
    rx_line = v;
    repeat (bit_len) @(negedge CLK);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    @(negedge CLK);
    start_cyc = cyc;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop);
  endtask

  task automatic wait_count(input logic lvl, input int limit, output int n);
    n = 0;
    while (Count_Sig !== lvl && n < limit) begin
      @(negedge CLK);
      n++;
    end
  endtask

  initial begin
    int d0, e0, n, t0, lat;
    logic saw_cnt;
    RSTn = 1'b0; rx_line = 1'b1; rx_en = 1'b1; bps_force = 1'b0;
    repeat (3) @(negedge CLK);
    chk("rst_count", Count_Sig, 0);
    chk("rst_data", RX_Data, 0);
    chk("rst_done", RX_Done_Sig, 0);
    chk("rst_err", RX_Err_Sig, 0);
    RSTn = 1'b1;
    repeat (20) @(negedge CLK);

    // 0x55 at the nominal bit period
    d0 = done_cnt; e0 = err_cnt;
    send_frame(8'h55, 1'b1);
    repeat (10) @(negedge CLK);
    lat = done_cyc - start_cyc;
    $display("info 0x55 latency %0d cycles", lat);
    chk("b55_done_once", done_cnt - d0, 1);
    chk("b55_data", RX_Data, 8'h55);
    chk("b55_latency", (lat >= 16450 && lat <= 16550), 1);
    chk("b55_count_low", Count_Sig, 0);
    chk("b55_no_err", err_cnt - e0, 0);

    // Start glitch
    repeat (50) @(negedge CLK);
    d0 = done_cnt; e0 = err_cnt;
    t0 = cyc;
    rx_line = 1'b0;
    repeat (100) @(negedge CLK);
    rx_line = 1'b1;
    wait_count(1'b1, 3000, n);
    chk("glitch_count_rise", n < 3000, 1);
    wait_count(1'b0, 3000, n);
    chk("glitch_count_fall", n < 3000, 1);
    chk("glitch_fall_time", ((cyc - t0) >= 860 && (cyc - t0) <= 890), 1);
    repeat (200) @(negedge CLK);
    chk("glitch_no_done", done_cnt - d0, 0);
    chk("glitch_no_err", err_cnt - e0, 0);
    chk("glitch_data", RX_Data, 8'h55);

    // Faster bit rate for the remaining frames
    bit_len = 200; half_len = 100;
    repeat (20) @(negedge CLK);

    // Back-to-back frames
    d0 = done_cnt;
    data_log.delete();
    send_frame(8'hA3, 1'b1);
    send_frame(8'h0F, 1'b1);
    repeat (20) @(negedge CLK);
    chk("b2b_done_count", done_cnt - d0, 2);
    if (data_log.size() >= 2) begin
      chk("b2b_first", data_log[0], 8'hA3);
      chk("b2b_second", data_log[1], 8'h0F);
    end else begin
      chk("b2b_log_size", data_log.size(), 2);
    end

    // Framing error after a good 0x55, then a held-low break
    send_frame(8'h55, 1'b1);
    repeat (20) @(negedge CLK);
    chk("pre_err_data", RX_Data, 8'h55);
    d0 = done_cnt; e0 = err_cnt;
    send_frame(8'hFF, 1'b0);
    saw_cnt = 1'b0;
    for (int i = 0; i < 5*bit_len; i++) begin
      @(negedge CLK);
      bps_force = ((i % 300) == 150);
      if (Count_Sig) saw_cnt = 1'b1;
    end
    bps_force = 1'b0;
    chk("ferr_err_once", err_cnt - e0, 1);
    chk("ferr_no_done", done_cnt - d0, 0);
    chk("ferr_data_kept", RX_Data, 8'h55);
    chk("break_no_count", saw_cnt, 0);
    rx_line = 1'b1;
    repeat (300) @(negedge CLK);

    // Enable dropped during data bit 3
    d0 = done_cnt; e0 = err_cnt;
    fork
      send_frame(8'h5A, 1'b1);
      begin
        repeat (4*bit_len + half_len + 1) @(negedge CLK);
        chk("abort_count_pre", Count_Sig, 1);
        rx_en = 1'b0;
        @(negedge CLK);
        chk("abort_count_off", Count_Sig, 0);
      end
    join
    repeat (300) @(negedge CLK);
    chk("abort_no_done", done_cnt - d0, 0);
    chk("abort_no_err", err_cnt - e0, 0);
    rx_en = 1'b1;
    repeat (20) @(negedge CLK);
    send_frame(8'h3C, 1'b1);
    repeat (20) @(negedge CLK);
    chk("post_abort_done", done_cnt - d0, 1);
    chk("post_abort_data", RX_Data, 8'h3C);

    // Reset pulse during data bit 5
    d0 = done_cnt; e0 = err_cnt;
    fork
      send_frame(8'hE5, 1'b1);
      begin
        repeat (6*bit_len + half_len + 1) @(negedge CLK);
        chk("rst_mid_count_pre", Count_Sig, 1);
        RSTn = 1'b0;
        @(negedge CLK);
        RSTn = 1'b1;
        chk("rst_mid_count", Count_Sig, 0);
        chk("rst_mid_data", RX_Data, 0);
        chk("rst_mid_done", RX_Done_Sig, 0);
        chk("rst_mid_err", RX_Err_Sig, 0);
      end
    join
    repeat (300) @(negedge CLK);
    chk("rst_mid_no_strobe", (done_cnt - d0) + (err_cnt - e0), 0);
    send_frame(8'h81, 1'b1);
    repeat (20) @(negedge CLK);
    chk("post_rst_done", done_cnt - d0, 1);
    chk("post_rst_data", RX_Data, 8'h81);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
